instr_fetch: RTL

- Instruction fetch stage directly upstream of the decoder (control).
- Sequences a program counter through a synchronous instruction memory that has 1-cycle read latency.
- Presents one 32-bit instruction per cycle on a registered output. Honours a pipeline stall with a 1-deep hold buffer so no fetched word is lost or duplicated.
- Emits all-zero words (decoded as NOP) as bubbles; signals completion after a programmed instruction count.

---
 rtl/instr_fetch.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Purpose : instruction fetch stage; walks a PC through a 1-cycle-latency
//           synchronous instruction memory and presents one word per cycle to
//           the decoder on a registered output, with all-zero bubbles when idle.
// Latency : start accepted at edge E0 -> read of address 0 during the next
//           cycle -> first instruction registered at E2; 1 instr/cycle after.
// Backpressure: stall freezes the output register and blocks new reads; a word
//           already in flight when stall rises is parked in a 1-deep hold
//           buffer and is delivered first once stall falls.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, prog_len   launch pulse and instruction count (sampled on accept)
//   stall             downstream cannot take a new instruction this cycle
//   imem_en/addr/data instruction memory read port (data one cycle after en)
//   instr, instr_valid, instr_pc   registered instruction to the decoder
//   busy, done        RUN/DRAIN and DONE state indications
module instr_fetch #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          stall,
  input  logic [0:31]   imem_data,
  output logic          imem_en,
  output logic [0:AW-1] imem_addr,
  output logic [0:31]   instr,
  output logic          instr_valid,
  output logic [0:AW-1] instr_pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,     state_d;
  logic [AW-1:0]   fetch_pc_q,  fetch_pc_d;
  logic [AW:0]     issued_q,    issued_d;
  logic [AW:0]     len_q,       len_d;

  // One read may be in flight; pend_pc_q remembers which address it was for.
  logic            pending_q,   pending_d;
  logic [AW-1:0]   pend_pc_q,   pend_pc_d;

  // 1-deep hold buffer for a word that returned while the output was stalled.
  logic            hold_vld_q,  hold_vld_d;
  logic [31:0]     hold_dat_q,  hold_dat_d;
  logic [AW-1:0]   hold_pc_q,   hold_pc_d;

  // Output register towards the decoder.
  logic [31:0]     instr_q,     instr_d;
  logic            instr_vld_q, instr_vld_d;
  logic [AW-1:0]   instr_pc_q,  instr_pc_d;

  logic            issue;
  logic            last_issue;
  logic            start_ok;
  logic            drain_empty;

  // A new read is only launched when the output can move (no stall) and the
  // hold buffer is empty; this keeps at most one word outside the output reg.
  assign issue       = (state_q == S_RUN) && !stall && !hold_vld_q;
  assign last_issue  = issue && ((issued_q + (AW+1)'(1)) == len_q);
  assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Finished once nothing is in flight or parked, and the final word on the
  // output has been accepted (or there is no valid word left on it).
  assign drain_empty = !pending_q && !hold_vld_q && (!instr_vld_q || !stall);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_d    = issued_q;
    len_d       = len_q;
    pending_d   = issue;
    pend_pc_d   = pend_pc_q;
    hold_vld_d  = hold_vld_q;
    hold_dat_d  = hold_dat_q;
    hold_pc_d   = hold_pc_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    instr_pc_d  = instr_pc_q;

    // Sequencer
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          fetch_pc_d = '0;
          issued_d   = '0;
          len_d      = prog_len;
          state_d    = (prog_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (issue) begin
          // Wraps to 0 after address 2^AW-1; harmless because DRAIN follows.
          fetch_pc_d = fetch_pc_q + AW'(1);
          issued_d   = issued_q + (AW+1)'(1);
        end
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_empty) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      pend_pc_d = fetch_pc_q;
    end

    // Output register and hold buffer, in priority order.
    if (stall) begin
      // Output frozen; a returning word is parked instead of being dropped.
      if (pending_q) begin
        hold_vld_d = 1'b1;
        hold_dat_d = imem_data;
        hold_pc_d  = pend_pc_q;
      end
    end else if (hold_vld_q) begin
      // Parked word goes first; no read was issued in this cycle, so there is
      // no memory return competing for the output.
      instr_d     = hold_dat_q;
      instr_vld_d = 1'b1;
      instr_pc_d  = hold_pc_q;
      hold_vld_d  = 1'b0;
    end else if (pending_q) begin
      instr_d     = imem_data;
      instr_vld_d = 1'b1;
      instr_pc_d  = pend_pc_q;
    end else begin
      // Bubble: all-zero word decodes as NOP; the pc is left as it was.
      instr_d     = '0;
      instr_vld_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= '0;
      issued_q    <= '0;
      len_q       <= '0;
      pending_q   <= 1'b0;
      pend_pc_q   <= '0;
      hold_vld_q  <= 1'b0;
      hold_dat_q  <= '0;
      hold_pc_q   <= '0;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      instr_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_q    <= issued_d;
      len_q       <= len_d;
      pending_q   <= pending_d;
      pend_pc_q   <= pend_pc_d;
      hold_vld_q  <= hold_vld_d;
      hold_dat_q  <= hold_dat_d;
      hold_pc_q   <= hold_pc_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_en     = issue;
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_vld_q;
  assign instr_pc    = instr_pc_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

endmodule
